alg_spi_master: RTL and testbench

SPI master that issues register reads and writes to the algorithm FPGA's SPI register file. It sits in the communication FPGA and drives the SCK/SSEL/MOSI pins, sampling MISO from the algorithm FPGA. Its host side is a single-request handshake: latch address/data, run one 32-bit frame, pulse completion with read data. It is the initiator end of the SPI link whose responder is the algorithm FPGA's SPI slave.

---
 rtl/alg_spi_master.sv | 162 ++++++++++++++++
 tb/tb_alg_spi_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alg_spi_master.sv
// SPI mode-0 master issuing one 32-bit register frame per host request:
// {wr, addr[14:0], wdata or zeros}, MSB first; the last 16 MISO bits form read data.
module alg_spi_master #(
  parameter int ClkDiv    = 4,
  parameter int GapCycles = 4
) (
  input  logic        clk50_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [14:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] rdata_o,
  output logic        SCK_o,
  output logic        SSEL_o,
  output logic        MOSI_o,
  input  logic        MISO_i
);

  localparam int CW = $clog2(ClkDiv);
  localparam int GW = $clog2(GapCycles + 1);
  localparam logic [CW-1:0] CMAX = CW'(ClkDiv - 1);
  localparam logic [GW-1:0] GMAX = GW'(GapCycles - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [GW-1:0] r_gap;
  logic [5:0]  r_bit;
  logic        r_wr;
  logic        r_sck;
  logic        r_ssel;
  logic        r_mosi;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_rdata;
  logic [31:0] r_tx;
  logic [15:0] r_rx;

  logic w_tick;
  logic w_last;
  logic w_accept;
  logic w_rise;
  logic w_fall_mid;

  assign w_tick   = (r_cnt == CMAX);
  assign w_last   = (r_bit == 6'd31);
  // The final GAP cycle doubles as an IDLE cycle so a held request restarts without a bubble.
  assign w_accept = req_i && ((r_state == S_IDLE) || ((r_state == S_GAP) && (r_gap == GMAX)));
  assign w_rise   = w_tick && ((r_state == S_SETUP) ||
                               ((r_state == S_SHIFT) && !r_sck && !w_last));
  assign w_fall_mid = w_tick && (r_state == S_SHIFT) && r_sck && !w_last;

  always_ff @(posedge clk50_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_bit   <= '0;
      r_wr    <= 1'b0;
      r_sck   <= 1'b0;
      r_ssel  <= 1'b1;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_state <= S_SETUP;
        r_cnt   <= '0;
        r_bit   <= '0;
        r_wr    <= wr_i;
        r_ssel  <= 1'b0;
        r_mosi  <= wr_i;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
          end
          S_SETUP: begin
            if (w_tick) begin
              r_cnt   <= '0;
              r_sck   <= 1'b1;
              r_state <= S_SHIFT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          // r_bit counts completed rising edges minus one; the 32nd period ends with a full low half.
          S_SHIFT: begin
            if (w_tick) begin
              r_cnt <= '0;
              if (r_sck) begin
                r_sck <= 1'b0;
                if (!w_last) r_mosi <= r_tx[30];
              end else if (w_last) begin
                r_state <= S_HOLD;
              end else begin
                r_sck <= 1'b1;
                r_bit <= r_bit + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_HOLD: begin
            if (w_tick) begin
              r_cnt   <= '0;
              r_gap   <= '0;
              r_ssel  <= 1'b1;
              r_mosi  <= 1'b0;
              r_done  <= 1'b1;
              if (!r_wr) r_rdata <= r_rx;
              r_state <= S_GAP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_GAP: begin
            if (r_gap == GMAX) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Shift registers carry data only; their contents are meaningless until a frame loads them.
  always_ff @(posedge clk50_i) begin
    if (w_accept) begin
      r_tx <= {wr_i, addr_i, (wr_i ? wdata_i : 16'h0000)};
    end else if (w_fall_mid) begin
      r_tx <= {r_tx[30:0], 1'b0};
    end
    if (w_rise) begin
      r_rx <= {r_rx[14:0], MISO_i};
    end
  end

  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign rdata_o = r_rdata;
  assign SCK_o   = r_sck;
  assign SSEL_o  = r_ssel;
  assign MOSI_o  = r_mosi;

endmodule

// File: tb/tb_alg_spi_master.sv
// Bench for alg_spi_master: three instances (ClkDiv 4/2/255) driven by a cycle-level
// slave model that records MOSI on SCK rises and serves MISO bits MSB first.
module tb_alg_spi_master;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [NI-1:0]         req;
  logic [NI-1:0]         wr;
  logic [NI-1:0][14:0]   addr;
  logic [NI-1:0][15:0]   wdata;
  logic [NI-1:0]         miso;
  wire  [NI-1:0]         w_busy;
  wire  [NI-1:0]         w_done;
  wire  [NI-1:0][15:0]   w_rdata;
  wire  [NI-1:0]         w_sck;
  wire  [NI-1:0]         w_ssel;
  wire  [NI-1:0]         w_mosi;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_rd [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CDV = (g == 0) ? 4 : (g == 1) ? 2 : 255;
    localparam int GPV = (g == 0) ? 4 : (g == 1) ? 1 : 3;
    alg_spi_master #(.ClkDiv(CDV), .GapCycles(GPV)) u_dut (
      .clk50_i (clk),
      .rst_i   (rst),
      .req_i   (req[g]),
      .wr_i    (wr[g]),
      .addr_i  (addr[g]),
      .wdata_i (wdata[g]),
      .busy_o  (w_busy[g]),
      .done_o  (w_done[g]),
      .rdata_o (w_rdata[g]),
      .SCK_o   (w_sck[g]),
      .SSEL_o  (w_ssel[g]),
      .MOSI_o  (w_mosi[g]),
      .MISO_i  (miso[g])
    );
  end

  function automatic int cd(input int k);
    return (k == 0) ? 4 : (k == 1) ? 2 : 255;
  endfunction

  function automatic int gp(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 3;
  endfunction

  // Called #1 after a clock edge with instance k idle; the next edge is the accept edge.
  task automatic issue_req(input int k, input bit w, input bit [14:0] a, input bit [15:0] d,
                           input bit keep);
    wr[k]    = w;
    addr[k]  = a;
    wdata[k] = d;
    req[k]   = 1'b1;
    @(posedge clk); #1;
    if (!keep) req[k] = 1'b0;
  endtask

  // Starts #1 after accept edge A and returns #1 after the done_o edge.
  task automatic do_frame(input int k, input bit w, input bit [14:0] a, input bit [15:0] d,
                          input bit [15:0] rd, input bit pulse);
    int c;
    int t;
    int rises;
    int first;
    int last;
    int badper;
    int donet;
    bit prev;
    logic [31:0] exp_frame;
    logic [31:0] resp;
    logic [31:0] cap;
    c = cd(k);
    exp_frame = {w, a, (w ? d : 16'h0000)};
    resp = {16'($urandom), rd};
    rises = 0; first = -1; last = -1; badper = 0; donet = -1; prev = 1'b0; cap = '0;
    n_cmp++;
    if ({w_ssel[k], w_busy[k], w_mosi[k], w_sck[k]} !== {1'b0, 1'b1, w, 1'b0}) begin
      n_bad++;
      $display("FAIL accept_outputs[%0d]: ssel/busy/mosi/sck got %b%b%b%b required 01%b0",
               k, w_ssel[k], w_busy[k], w_mosi[k], w_sck[k], w);
    end
    miso[k] = resp[31];
    for (t = 1; t <= 66 * c + 8; t++) begin
      @(posedge clk); #1;
      if (pulse) req[k] = (t == 10 || t == 200);
      if (w_sck[k] && !prev) begin
        if (first < 0) first = t;
        else if (t - last != 2 * c) badper++;
        last = t;
        cap = {cap[30:0], w_mosi[k]};
        rises++;
        if (rises < 32) miso[k] = resp[31 - rises];
      end
      prev = w_sck[k];
      if (w_done[k]) begin
        donet = t;
        break;
      end
    end
    req[k] = req[k] & ~pulse;
    if (!w) exp_rd[k] = rd;
    n_cmp++;
    if (donet != 66 * c) begin
      n_bad++;
      $display("FAIL done_time[%0d]: got A+%0d required A+%0d", k, donet, 66 * c);
    end
    n_cmp++;
    if (rises != 32 || cap !== exp_frame) begin
      n_bad++;
      $display("FAIL mosi_frame[%0d]: got %h (%0d rises) required %h (32 rises)",
               k, cap, rises, exp_frame);
    end
    n_cmp++;
    if (first != c || badper != 0) begin
      n_bad++;
      $display("FAIL sck_timing[%0d]: first rise A+%0d bad periods %0d required A+%0d and 0",
               k, first, badper, c);
    end
    n_cmp++;
    if ({w_ssel[k], w_mosi[k], w_busy[k], w_sck[k]} !== 4'b1010) begin
      n_bad++;
      $display("FAIL done_outputs[%0d]: ssel/mosi/busy/sck got %b%b%b%b required 1010",
               k, w_ssel[k], w_mosi[k], w_busy[k], w_sck[k]);
    end
    n_cmp++;
    if (w_rdata[k] !== exp_rd[k]) begin
      n_bad++;
      $display("FAIL rdata[%0d]: got %h required %h", k, w_rdata[k], exp_rd[k]);
    end
  endtask

  // Starts #1 after the done_o edge with req_i low; busy_o must fall exactly GapCycles later.
  task automatic finish_gap(input int k);
    int bad;
    bad = 0;
    for (int g = 1; g <= gp(k); g++) begin
      @(posedge clk); #1;
      if (w_done[k] !== 1'b0 || w_ssel[k] !== 1'b1) bad++;
      if (w_busy[k] !== ((g < gp(k)) ? 1'b1 : 1'b0)) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL gap[%0d]: %0d bad cycles required 0", k, bad);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if ({w_sck[k], w_ssel[k], w_mosi[k], w_busy[k], w_done[k], w_rdata[k]} !==
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: got sck%b ssel%b mosi%b busy%b done%b rdata%h required 0 1 0 0 0 0000",
                 k, w_sck[k], w_ssel[k], w_mosi[k], w_busy[k], w_done[k], w_rdata[k]);
      end
    end
  endtask

  task automatic test_write();
    issue_req(0, 1'b1, 15'h1234, 16'hBEEF, 1'b0);
    do_frame(0, 1'b1, 15'h1234, 16'hBEEF, 16'h0000, 1'b0);
    finish_gap(0);
  endtask

  task automatic test_read();
    issue_req(0, 1'b0, 15'h0005, 16'h7777, 1'b0);
    do_frame(0, 1'b0, 15'h0005, 16'h7777, 16'hA5C3, 1'b0);
    finish_gap(0);
  endtask

  task automatic test_random(input int k, input int n);
    bit w;
    bit [14:0] a;
    bit [15:0] d;
    bit [15:0] rd;
    for (int i = 0; i < n; i++) begin
      w = 1'($urandom); a = 15'($urandom); d = 16'($urandom); rd = 16'($urandom);
      issue_req(k, w, a, d, 1'b0);
      do_frame(k, w, a, d, rd, 1'b0);
      finish_gap(k);
    end
  endtask

  task automatic test_busy_reject();
    int ndone;
    int nsel;
    issue_req(0, 1'b1, 15'h2A5A, 16'h1357, 1'b0);
    do_frame(0, 1'b1, 15'h2A5A, 16'h1357, 16'h0000, 1'b1);
    finish_gap(0);
    ndone = 0; nsel = 0;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #1;
      if (w_done[0]) ndone++;
      if (!w_ssel[0] || w_busy[0]) nsel++;
    end
    n_cmp++;
    if (ndone != 0 || nsel != 0) begin
      n_bad++;
      $display("FAIL busy_reject: extra done %0d, active cycles %0d required 0 and 0", ndone, nsel);
    end
  endtask

  task automatic test_back_to_back();
    bit [14:0] a2;
    bit [15:0] d2;
    bit [15:0] rd2;
    int bad;
    a2 = 15'($urandom); d2 = 16'($urandom); rd2 = 16'($urandom);
    issue_req(0, 1'b0, 15'h0F0F, 16'h0000, 1'b1);
    do_frame(0, 1'b0, 15'h0F0F, 16'h0000, 16'h3C96, 1'b0);
    bad = 0;
    for (int g = 1; g <= 4; g++) begin
      @(posedge clk); #1;
      if (g == 1) begin
        addr[0] = a2; wdata[0] = d2;
        if (w_done[0] !== 1'b0) bad++;
      end
      if (w_busy[0] !== 1'b1) bad++;
      if (w_ssel[0] !== ((g < 4) ? 1'b1 : 1'b0)) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL back_to_back_gap: %0d bad cycles required 0 (accept at A+268)", bad);
    end
    req[0] = 1'b0;
    do_frame(0, 1'b0, a2, d2, rd2, 1'b0);
    finish_gap(0);
  endtask

  task automatic test_reset_mid();
    int bad;
    issue_req(0, 1'b0, 15'h4321, 16'h0000, 1'b0);
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      miso[0] = 1'($urandom);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({w_sck[0], w_ssel[0], w_mosi[0], w_busy[0], w_done[0], w_rdata[0]} !==
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      n_bad++;
      $display("FAIL reset_mid_frame: got sck%b ssel%b mosi%b busy%b done%b rdata%h required 0 1 0 0 0 0000",
               w_sck[0], w_ssel[0], w_mosi[0], w_busy[0], w_done[0], w_rdata[0]);
    end
    for (int k = 0; k < NI; k++) exp_rd[k] = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #1;
      if (w_done[0] || !w_ssel[0] || w_busy[0]) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL reset_no_done: %0d active cycles after reset required 0", bad);
    end
    test_random(0, 1);
  endtask

  initial begin
    rst = 1'b1;
    req = '0; wr = '0; addr = '0; wdata = '0; miso = '0;
    for (int k = 0; k < NI; k++) exp_rd[k] = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_write();
    test_read();
    test_random(0, 4);
    test_busy_reject();
    test_back_to_back();
    test_reset_mid();
    test_random(1, 4);
    issue_req(2, 1'b0, 15'h5A5A, 16'h0000, 1'b0);
    do_frame(2, 1'b0, 15'h5A5A, 16'h0000, 16'hC0DE, 1'b0);
    finish_gap(2);
    test_random(2, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
